// File: rtl/led_phase_scheduler.sv
// LED/ADC time-multiplexer: runs RED, IR and dark phases per frame on the shared PGA/ADC path
// and publishes per-frame averages with the ambient level subtracted.
module led_phase_scheduler #(
    parameter int SETTLE_CYCLES = 3,
    parameter int SAMPLE_CYCLES = 8,
    parameter int ADC_W         = 8
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [ADC_W-1:0] ADC,
    input  logic [6:0]       RED_DC_Comp,
    input  logic [6:0]       IR_DC_Comp,
    input  logic [3:0]       RED_PGA,
    input  logic [3:0]       IR_PGA,
    output logic             LED_RED,
    output logic             LED_IR,
    output logic [6:0]       DC_Comp,
    output logic [3:0]       PGA_Gain,
    output logic [ADC_W-1:0] RED_ADC_Value,
    output logic [ADC_W-1:0] IR_ADC_Value,
    output logic [ADC_W-1:0] AMB_ADC_Value,
    output logic             sample_valid,
    output logic             busy
);
    localparam int LOG2  = $clog2(SAMPLE_CYCLES);
    localparam int ACC_W = ADC_W + LOG2;
    localparam int CNT_W = 7;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, RED_SETTLE, RED_SAMPLE, IR_SETTLE, IR_SAMPLE, AMB_SETTLE, AMB_SAMPLE, UPDATE
    } state_t;

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] acc, acc_sum;
    logic [ADC_W-1:0] avg_now, red_avg, ir_avg, amb_avg;
    logic [6:0]       red_dc_lat, ir_dc_lat;
    logic [3:0]       red_pga_lat, ir_pga_lat;
    logic             in_sample;

    // Ambient subtraction, floored at zero when the lit phase reads below ambient.
    function automatic logic [ADC_W-1:0] floor_sub(input logic [ADC_W-1:0] a,
                                                   input logic [ADC_W-1:0] b);
        logic signed [ADC_W:0] diff;
        diff = $signed({1'b0, a}) - $signed({1'b0, b});
        return (diff > 0) ? diff[ADC_W-1:0] : '0;
    endfunction

    assign in_sample = (state == RED_SAMPLE) || (state == IR_SAMPLE) || (state == AMB_SAMPLE);
    assign acc_sum   = acc + ACC_W'(ADC);
    assign avg_now   = acc_sum[ACC_W-1:LOG2];
    assign busy      = (state != IDLE);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:       if (enable) next_state = RED_SETTLE;
            RED_SETTLE: if (cnt == SETTLE_LAST) next_state = RED_SAMPLE;
            RED_SAMPLE: if (cnt == SAMPLE_LAST) next_state = IR_SETTLE;
            IR_SETTLE:  if (cnt == SETTLE_LAST) next_state = IR_SAMPLE;
            IR_SAMPLE:  if (cnt == SAMPLE_LAST) next_state = AMB_SETTLE;
            AMB_SETTLE: if (cnt == SETTLE_LAST) next_state = AMB_SAMPLE;
            AMB_SAMPLE: if (cnt == SAMPLE_LAST) next_state = UPDATE;
            UPDATE:     next_state = enable ? RED_SETTLE : IDLE;
            default:    next_state = IDLE;
        endcase
        // Dropping enable abandons the frame, except in UPDATE where results are already final.
        if (!enable && state != IDLE && state != UPDATE) next_state = IDLE;
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= (next_state != state || state == IDLE) ? '0 : cnt + 1'b1;
        end
    end

    // Accumulator is zero on entry to every phase; averages captured on each SAMPLE exit.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            red_avg <= '0;
            ir_avg  <= '0;
            amb_avg <= '0;
        end else begin
            acc <= (in_sample && next_state == state) ? acc_sum : '0;
            if (state == RED_SAMPLE && next_state == IR_SETTLE)  red_avg <= avg_now;
            if (state == IR_SAMPLE  && next_state == AMB_SETTLE) ir_avg  <= avg_now;
            if (state == AMB_SAMPLE && next_state == UPDATE)     amb_avg <= avg_now;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            LED_RED       <= 1'b0;
            LED_IR        <= 1'b0;
            DC_Comp       <= '0;
            PGA_Gain      <= '0;
            RED_ADC_Value <= '0;
            IR_ADC_Value  <= '0;
            AMB_ADC_Value <= '0;
            sample_valid  <= 1'b0;
            red_dc_lat    <= '0;
            ir_dc_lat     <= '0;
            red_pga_lat   <= '0;
            ir_pga_lat    <= '0;
        end else begin
            sample_valid <= (state == UPDATE);
            if (state == UPDATE) begin
                AMB_ADC_Value <= amb_avg;
                RED_ADC_Value <= floor_sub(red_avg, amb_avg);
                IR_ADC_Value  <= floor_sub(ir_avg, amb_avg);
            end
            if (next_state != state) begin
                case (next_state)
                    RED_SETTLE: begin
                        LED_RED     <= 1'b1;
                        LED_IR      <= 1'b0;
                        DC_Comp     <= RED_DC_Comp;
                        PGA_Gain    <= RED_PGA;
                        red_dc_lat  <= RED_DC_Comp;
                        ir_dc_lat   <= IR_DC_Comp;
                        red_pga_lat <= RED_PGA;
                        ir_pga_lat  <= IR_PGA;
                    end
                    IR_SETTLE: begin
                        LED_RED  <= 1'b0;
                        LED_IR   <= 1'b1;
                        DC_Comp  <= ir_dc_lat;
                        PGA_Gain <= ir_pga_lat;
                    end
                    AMB_SETTLE: begin
                        LED_RED  <= 1'b0;
                        LED_IR   <= 1'b0;
                        DC_Comp  <= red_dc_lat;
                        PGA_Gain <= red_pga_lat;
                    end
                    IDLE: begin
                        LED_RED <= 1'b0;
                        LED_IR  <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_phase_scheduler.sv
// Directed bench for led_phase_scheduler: table of per-frame ADC patterns plus reset/abort sequences.
module tb_led_phase_scheduler;
    logic       CLK = 1'b0;
    logic       rst_n, enable;
    logic [7:0] ADC;
    logic [6:0] RED_DC_Comp, IR_DC_Comp, DC_Comp;
    logic [3:0] RED_PGA, IR_PGA, PGA_Gain;
    logic       LED_RED, LED_IR, sample_valid, busy;
    logic [7:0] RED_ADC_Value, IR_ADC_Value, AMB_ADC_Value;

    int errors = 0;
    int checks = 0;

    led_phase_scheduler #(.SETTLE_CYCLES(3), .SAMPLE_CYCLES(8), .ADC_W(8)) dut (
        .CLK(CLK), .rst_n(rst_n), .enable(enable), .ADC(ADC),
        .RED_DC_Comp(RED_DC_Comp), .IR_DC_Comp(IR_DC_Comp),
        .RED_PGA(RED_PGA), .IR_PGA(IR_PGA),
        .LED_RED(LED_RED), .LED_IR(LED_IR), .DC_Comp(DC_Comp), .PGA_Gain(PGA_Gain),
        .RED_ADC_Value(RED_ADC_Value), .IR_ADC_Value(IR_ADC_Value), .AMB_ADC_Value(AMB_ADC_Value),
        .sample_valid(sample_valid), .busy(busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] red_a, red_b, ir, amb, settle;
        logic       chg;
        logic [7:0] e_red, e_ir, e_amb;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Starts in cycle 0 of a frame (RED_SETTLE just entered); ends in cycle 0 of the next frame.
    task automatic run_frame(input vec_t v);
        int         pulses;
        logic [6:0] rdc, idc;
        logic [3:0] rpga, ipga;
        pulses = 0;
        rdc = RED_DC_Comp; idc = IR_DC_Comp; rpga = RED_PGA; ipga = IR_PGA;
        for (int c = 0; c < 34; c++) begin
            if (c >= 3 && c <= 10)       ADC = ((c - 3) % 2 == 0) ? v.red_a : v.red_b;
            else if (c >= 14 && c <= 21) ADC = v.ir;
            else if (c >= 25 && c <= 32) ADC = v.amb;
            else                         ADC = v.settle;
            if (c >= 1 && sample_valid) pulses++;
            if (c == 0) begin
                chk("red_led_on", LED_RED, 1);
                chk("red_ir_led_off", LED_IR, 0);
                chk("red_dc", DC_Comp, rdc);
                chk("red_pga", PGA_Gain, rpga);
            end
            if (c == 11) begin
                chk("ir_led_on", {LED_RED, LED_IR}, 2'b01);
                chk("ir_dc", DC_Comp, idc);
                chk("ir_pga", PGA_Gain, ipga);
            end
            if (c == 14 && v.chg) begin
                RED_DC_Comp = 7'd60;
                RED_PGA     = 4'd6;
            end
            if (c == 20) chk("busy_in_frame", busy, 1);
            if (c == 22) begin
                chk("amb_leds_off", {LED_RED, LED_IR}, 2'b00);
                chk("amb_dc", DC_Comp, rdc);
                chk("amb_pga", PGA_Gain, rpga);
            end
            step();
        end
        chk("no_midframe_valid", pulses, 0);
        chk("sample_valid", sample_valid, 1);
        chk("red_value", RED_ADC_Value, v.e_red);
        chk("ir_value", IR_ADC_Value, v.e_ir);
        chk("amb_value", AMB_ADC_Value, v.e_amb);
    endtask

    initial begin
        vecs[0] = '{8'd200, 8'd200, 8'd150, 8'd20,  8'd0,   1'b0, 8'd180, 8'd130, 8'd20};
        vecs[1] = '{8'd200, 8'd200, 8'd50,  8'd60,  8'd255, 1'b0, 8'd140, 8'd0,   8'd60};
        vecs[2] = '{8'd0,   8'd255, 8'd10,  8'd0,   8'd255, 1'b0, 8'd127, 8'd10,  8'd0};
        vecs[3] = '{8'd100, 8'd100, 8'd100, 8'd100, 8'd255, 1'b1, 8'd0,   8'd0,   8'd100};
        vecs[4] = '{8'd100, 8'd100, 8'd100, 8'd0,   8'd255, 1'b0, 8'd100, 8'd100, 8'd0};
        vecs[5] = '{8'd7,   8'd8,   8'd3,   8'd2,   8'd0,   1'b0, 8'd5,   8'd1,   8'd2};
        vecs[6] = '{8'd30,  8'd30,  8'd31,  8'd30,  8'd200, 1'b0, 8'd0,   8'd1,   8'd30};

        rst_n = 1'b0; enable = 1'b0; ADC = 8'd0;
        RED_DC_Comp = 7'd44; RED_PGA = 4'd4; IR_DC_Comp = 7'd20; IR_PGA = 4'd2;
        step(); step();
        chk("reset_outputs", {LED_RED, LED_IR, DC_Comp, PGA_Gain, sample_valid, busy}, 0);
        chk("reset_values", {RED_ADC_Value, IR_ADC_Value, AMB_ADC_Value}, 0);
        rst_n = 1'b1;
        step();
        chk("idle_busy", busy, 0);

        enable = 1'b1;
        step();
        for (int i = 0; i < 7; i++) run_frame(vecs[i]);

        // Abort in IR_SAMPLE: results of the last frame must survive.
        for (int c = 0; c < 15; c++) step();
        enable = 1'b0;
        step();
        chk("abort_busy", busy, 0);
        chk("abort_leds", {LED_RED, LED_IR}, 2'b00);
        begin
            int pulses;
            pulses = 0;
            for (int c = 0; c < 40; c++) begin
                if (sample_valid) pulses++;
                step();
            end
            chk("abort_no_valid", pulses, 0);
        end
        chk("abort_hold_red", RED_ADC_Value, vecs[6].e_red);
        chk("abort_hold_ir", IR_ADC_Value, vecs[6].e_ir);
        chk("abort_hold_amb", AMB_ADC_Value, vecs[6].e_amb);

        enable = 1'b1;
        step();
        run_frame(vecs[0]);

        // Asynchronous reset in the middle of RED_SAMPLE.
        for (int c = 0; c < 5; c++) step();
        chk("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_ctrl", {LED_RED, LED_IR, DC_Comp, PGA_Gain, sample_valid, busy}, 0);
        chk("async_reset_values", {RED_ADC_Value, IR_ADC_Value, AMB_ADC_Value}, 0);
        enable = 1'b0;
        step();
        rst_n = 1'b1;
        step(); step();
        chk("post_reset_idle", {busy, LED_RED, LED_IR, sample_valid}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
